// File: rtl/uart_dbg_pkg.sv
// Shared constants and types for the UART debug bus master.
// Holds command/response codes, FSM state encoding, frame lengths,
// the bus request payload and a byte-select helper.
package uart_dbg_pkg;

   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 3;

   // Command and response bytes
   localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
   localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
   localparam logic [BYTE_W-1:0] RSP_ACK   = 8'h06;
   localparam logic [BYTE_W-1:0] RSP_NAK   = 8'h15;

   // FSM state encoding
   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_ADDR    = 3'd1;
   localparam logic [STATE_W-1:0] ST_DATA    = 3'd2;
   localparam logic [STATE_W-1:0] ST_ACCESS  = 3'd3;
   localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd4;
   localparam logic [STATE_W-1:0] ST_TX      = 3'd5;

   // Payload bytes following the opcode
   localparam logic [CNT_W-1:0] ADDR_LEN       = 3'd2;
   localparam logic [CNT_W-1:0] WR_PAYLOAD_LEN = 3'd6;
   localparam logic [CNT_W-1:0] RD_PAYLOAD_LEN = 3'd2;

   // Registered bus request presented to the memory/MMIO mux
   typedef struct packed {
      logic [3:0]        we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] din;
   } mem_req_t;

   // Little-endian byte select from a 32-bit word
   function automatic logic [BYTE_W-1:0] byte_of(input logic [DATA_W-1:0] word,
                                                 input logic [1:0]        idx);
      return BYTE_W'(word >> {idx, 3'b000});
   endfunction

endpackage

// File: rtl/uart_dbg_tx_seq.sv
// Response byte sequencer: sends a 1- or 4-byte little-endian response
// over a valid/ready byte handshake.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           launch a response (ignored while busy)
//   word, four      response word; four=1 sends 4 bytes, else only word[7:0]
//   tx_valid/data   byte to uart, held stable until tx_ready
//   tx_ready        uart can accept
//   done_c          high in the cycle the final byte is accepted
module uart_dbg_tx_seq
   import uart_dbg_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] word,
   input  logic              four,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic [BYTE_W-1:0] tx_data,
   output logic              done_c
);

   logic [DATA_W-1:0] word_q, word_nxt;
   logic [1:0]        idx, idx_nxt;
   logic [1:0]        last, last_nxt;
   logic              valid_nxt;
   logic [BYTE_W-1:0] data_nxt;
   logic              fire;

   assign fire   = tx_valid && tx_ready;
   assign done_c = fire && (idx == last);

   // Next-state: load on start, advance one byte per accepted handshake
   always_comb begin
      word_nxt  = word_q;
      idx_nxt   = idx;
      last_nxt  = last;
      valid_nxt = tx_valid;
      data_nxt  = tx_data;
      if (!tx_valid) begin
         if (start) begin
            word_nxt  = word;
            idx_nxt   = 2'd0;
            last_nxt  = four ? 2'd3 : 2'd0;
            valid_nxt = 1'b1;
            data_nxt  = word[BYTE_W-1:0];
         end
      end else if (fire) begin
         if (idx == last) begin
            valid_nxt = 1'b0;
         end else begin
            idx_nxt  = idx + 2'd1;
            data_nxt = byte_of(word_q, idx + 2'd1);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q   <= '0;
         idx      <= '0;
         last     <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else begin
         word_q   <= word_nxt;
         idx      <= idx_nxt;
         last     <= last_nxt;
         tx_valid <= valid_nxt;
         tx_data  <= data_nxt;
      end
   end

endmodule

// File: rtl/uart_dbg_master.sv
// UART debug bus master: parses 'W'/'R' command frames from the uart,
// performs one 32-bit access on the shared memory bus while stalling the
// CPU, and returns ACK / read data / NAK bytes.
// Optional feature: define UART_DBG_TIMEOUT_EN to abandon partial frames
// after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   rx_data/valid/ready    received byte handshake
//   tx_data/valid/ready    response byte handshake
//   mem_en/we/addr/din     single-cycle bus access request
//   mem_dout               read data, valid MEM_READ_LATENCY cycles after mem_en
//   cpu_stall              high while a command owns the bus
module uart_dbg_master
   import uart_dbg_pkg::*;
#(
   parameter int unsigned MEM_READ_LATENCY = 1,
   parameter int unsigned TIMEOUT_CYCLES   = 5_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              cpu_stall
);

   localparam int unsigned LAT_W = (MEM_READ_LATENCY < 2) ? 1 : $clog2(MEM_READ_LATENCY + 1);

   logic [STATE_W-1:0] state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CNT_W-1:0]   frame_len, cnt_inc;
   logic               is_wr, is_wr_nxt;
   logic [ADDR_W-1:0]  addr_q, addr_nxt;
   logic [DATA_W-1:0]  data_q, data_nxt;
   mem_req_t           req, req_nxt;
   logic               mem_en_nxt;
   logic               stall_nxt;
   logic               rx_ready_nxt;
   logic               rsp_start, rsp_start_nxt;
   logic [DATA_W-1:0]  rsp_word, rsp_word_nxt;
   logic               rsp_four, rsp_four_nxt;
   logic [LAT_W-1:0]   wait_cnt, wait_nxt;
   logic               rx_fire;
   logic               tx_done_c;

`ifdef UART_DBG_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] to_cnt, to_cnt_nxt;
`endif

   assign rx_fire  = rx_valid && rx_ready;
   assign mem_we   = req.we;
   assign mem_addr = req.addr;
   assign mem_din  = req.din;

   // Next-state and registered-output logic
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      is_wr_nxt     = is_wr;
      addr_nxt      = addr_q;
      data_nxt      = data_q;
      req_nxt       = req;
      req_nxt.we    = 4'h0;
      mem_en_nxt    = 1'b0;
      stall_nxt     = cpu_stall;
      rsp_start_nxt = 1'b0;
      rsp_word_nxt  = rsp_word;
      rsp_four_nxt  = rsp_four;
      wait_nxt      = wait_cnt;
      frame_len     = is_wr ? WR_PAYLOAD_LEN : RD_PAYLOAD_LEN;
      // never wraps: parks at the frame length
      cnt_inc       = (cnt == frame_len) ? cnt : cnt + 3'd1;
`ifdef UART_DBG_TIMEOUT_EN
      to_cnt_nxt    = '0;
`endif

      case (state)
         ST_IDLE: begin
            if (rx_fire) begin
               if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                  is_wr_nxt = (rx_data == CMD_WRITE);
                  cnt_nxt   = '0;
                  stall_nxt = 1'b1;
                  state_nxt = ST_ADDR;
               end else begin
                  rsp_word_nxt  = {24'h0, RSP_NAK};
                  rsp_four_nxt  = 1'b0;
                  rsp_start_nxt = 1'b1;
                  state_nxt     = ST_TX;
               end
            end
         end

         ST_ADDR: begin
            if (rx_fire) begin
               cnt_nxt = cnt_inc;
               if (cnt != ADDR_LEN - 3'd1) begin
                  addr_nxt[7:0] = rx_data;
               end else begin
                  // A1[7:6] fall outside the 14-bit byte address
                  addr_nxt[ADDR_W-1:8] = rx_data[5:0];
                  if (is_wr) begin
                     state_nxt = ST_DATA;
                  end else begin
                     req_nxt.addr = {rx_data[5:0], addr_q[7:0]};
                     mem_en_nxt   = 1'b1;
                     state_nxt    = ST_ACCESS;
                  end
               end
            end
         end

         ST_DATA: begin
            if (rx_fire) begin
               cnt_nxt  = cnt_inc;
               // little-endian: each new byte enters at the top
               data_nxt = {rx_data, data_q[DATA_W-1:8]};
               if (cnt == WR_PAYLOAD_LEN - 3'd1) begin
                  req_nxt.addr = addr_q;
                  req_nxt.din  = {rx_data, data_q[DATA_W-1:8]};
                  req_nxt.we   = 4'hF;
                  mem_en_nxt   = 1'b1;
                  state_nxt    = ST_ACCESS;
               end
            end
         end

         ST_ACCESS: begin
            if (is_wr) begin
               rsp_word_nxt  = {24'h0, RSP_ACK};
               rsp_four_nxt  = 1'b0;
               rsp_start_nxt = 1'b1;
               state_nxt     = ST_TX;
            end else if (MEM_READ_LATENCY == 0) begin
               rsp_word_nxt  = mem_dout;
               rsp_four_nxt  = 1'b1;
               rsp_start_nxt = 1'b1;
               state_nxt     = ST_TX;
            end else begin
               wait_nxt  = LAT_W'(1);
               state_nxt = ST_RD_WAIT;
            end
         end

         ST_RD_WAIT: begin
            if (wait_cnt == LAT_W'(MEM_READ_LATENCY)) begin
               rsp_word_nxt  = mem_dout;
               rsp_four_nxt  = 1'b1;
               rsp_start_nxt = 1'b1;
               state_nxt     = ST_TX;
            end else begin
               wait_nxt = wait_cnt + LAT_W'(1);
            end
         end

         ST_TX: begin
            if (tx_done_c) begin
               state_nxt = ST_IDLE;
               stall_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            stall_nxt = 1'b0;
         end
      endcase

`ifdef UART_DBG_TIMEOUT_EN
      // silent abandon of a stalled partial frame
      if ((state == ST_ADDR || state == ST_DATA) && !rx_fire) begin
         if (to_cnt == TO_LAST) begin
            state_nxt = ST_IDLE;
            stall_nxt = 1'b0;
         end else begin
            to_cnt_nxt = to_cnt + 32'd1;
         end
      end
`endif

      rx_ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_ADDR) || (state_nxt == ST_DATA);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         is_wr     <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         req       <= '0;
         mem_en    <= 1'b0;
         cpu_stall <= 1'b0;
         rx_ready  <= 1'b1;
         rsp_start <= 1'b0;
         rsp_word  <= '0;
         rsp_four  <= 1'b0;
         wait_cnt  <= '0;
`ifdef UART_DBG_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         is_wr     <= is_wr_nxt;
         addr_q    <= addr_nxt;
         data_q    <= data_nxt;
         req       <= req_nxt;
         mem_en    <= mem_en_nxt;
         cpu_stall <= stall_nxt;
         rx_ready  <= rx_ready_nxt;
         rsp_start <= rsp_start_nxt;
         rsp_word  <= rsp_word_nxt;
         rsp_four  <= rsp_four_nxt;
         wait_cnt  <= wait_nxt;
`ifdef UART_DBG_TIMEOUT_EN
         to_cnt    <= to_cnt_nxt;
`endif
      end
   end

   uart_dbg_tx_seq u_tx_seq (
      .clk      (clk),
      .reset    (reset),
      .start    (rsp_start),
      .word     (rsp_word),
      .four     (rsp_four),
      .tx_ready (tx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .done_c   (tx_done_c)
   );

endmodule

// File: tb/tb_uart_dbg_master.sv
// Directed bench for uart_dbg_master: write, read, bad opcode, tx
// backpressure, mid-frame reset and (with UART_DBG_TIMEOUT_EN) timeout.
`timescale 1ns/1ps
module tb_uart_dbg_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        cpu_stall;

   logic [31:0] rd_word = 32'h0;
   logic        en_d = 1'b0;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   uart_dbg_master #(.MEM_READ_LATENCY(1), .TIMEOUT_CYCLES(100)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .cpu_stall (cpu_stall)
   );

   // Memory with one-cycle read latency; garbage outside the valid cycle
   always @(posedge clk) en_d <= mem_en;
   assign mem_dout = en_d ? rd_word : 32'hBAD0_BAD0;

   // Bus / uart monitors
   int unsigned en_cnt = 0;
   int unsigned tx_n = 0;
   int unsigned stall_cyc = 0;
   int unsigned unstable = 0;
   logic [7:0]  tx_log [0:255];
   logic [3:0]  cap_we = 4'h0;
   logic [13:0] cap_addr = 14'h0;
   logic [31:0] cap_din = 32'h0;
   logic        hold_pend = 1'b0;
   logic [7:0]  hold_data = 8'h00;

   always @(negedge clk) begin
      if (mem_en) begin
         en_cnt   <= en_cnt + 1;
         cap_we   <= mem_we;
         cap_addr <= mem_addr;
         cap_din  <= mem_din;
      end
      if (tx_valid && tx_ready) begin
         tx_log[8'(tx_n)] <= tx_data;
         tx_n <= tx_n + 1;
      end
      if (cpu_stall) stall_cyc <= stall_cyc + 1;
      if (hold_pend && !reset && (!tx_valid || tx_data != hold_data)) unstable <= unstable + 1;
      hold_pend <= tx_valid && !tx_ready;
      hold_data <= tx_data;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rx_ready", 32'(rx_ready), 32'h1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   // Returns right after the edge that accepted the target-th byte
   task automatic wait_tx(input string tag, input int unsigned target);
      int n;
      n = 0;
      while (tx_n < target && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(tag, tx_n, target);
   endtask

   int unsigned e0, t0, s0;
   int n;

   initial begin
      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rx_ready", 32'(rx_ready), 32'h1);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_tx_data",  32'(tx_data),  32'h0);
      check("rst_mem_en",   32'(mem_en),   32'h0);
      check("rst_mem_we",   32'(mem_we),   32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_mem_din",  mem_din,       32'h0);
      check("rst_stall",    32'(cpu_stall), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 1: write 57 10 00 EF BE AD DE
      e0 = en_cnt; t0 = tx_n;
      send_byte(8'h57);
      check("wr_stall_on", 32'(cpu_stall), 32'h1);
      send_byte(8'h10); send_byte(8'h00);
      send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      wait_tx("wr_tx_cnt", t0 + 1);
      check("wr_stall_off", 32'(cpu_stall), 32'h0);
      check("wr_rx_ready",  32'(rx_ready),  32'h1);
      check("wr_en_cnt",    en_cnt - e0,    32'h1);
      check("wr_addr",      32'(cap_addr),  32'h0010);
      check("wr_we",        32'(cap_we),    32'hF);
      check("wr_din",       cap_din,        32'hDEADBEEF);
      check("wr_ack",       32'(tx_log[8'(t0)]), 32'h06);

      // 2: read 52 10 00, latency 1
      rd_word = 32'h12345678;
      e0 = en_cnt; t0 = tx_n;
      send_byte(8'h52); send_byte(8'h10); send_byte(8'h00);
      wait_tx("rd_tx_cnt", t0 + 4);
      check("rd_stall_off", 32'(cpu_stall), 32'h0);
      check("rd_en_cnt",    en_cnt - e0,    32'h1);
      check("rd_we",        32'(cap_we),    32'h0);
      check("rd_addr",      32'(cap_addr),  32'h0010);
      check("rd_b0", 32'(tx_log[8'(t0)]),     32'h78);
      check("rd_b1", 32'(tx_log[8'(t0 + 1)]), 32'h56);
      check("rd_b2", 32'(tx_log[8'(t0 + 2)]), 32'h34);
      check("rd_b3", 32'(tx_log[8'(t0 + 3)]), 32'h12);

      // 3: bad opcode, back-to-back after the read
      e0 = en_cnt; t0 = tx_n; s0 = stall_cyc;
      send_byte(8'h41);
      wait_tx("nak_tx_cnt", t0 + 1);
      check("nak_byte",   32'(tx_log[8'(t0)]), 32'h15);
      check("nak_en_cnt", en_cnt - e0,         32'h0);
      check("nak_stall",  stall_cyc - s0,      32'h0);

      // 4: tx backpressure for 20 cycles; A1[7:6] ignored
      rd_word = 32'hCAFEF00D;
      e0 = en_cnt; t0 = tx_n;
      tx_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h24); send_byte(8'hC1);
      n = 0;
      while (!tx_valid && n < 200) begin
         @(posedge clk);
         #2;
         n++;
      end
      repeat (20) @(posedge clk);
      #2;
      check("bp_valid_held", 32'(tx_valid), 32'h1);
      check("bp_data_held",  32'(tx_data),  32'h0D);
      check("bp_no_accept",  tx_n - t0,     32'h0);
      tx_ready = 1'b1;
      wait_tx("bp_tx_cnt", t0 + 4);
      repeat (5) @(posedge clk);
      #2;
      check("bp_no_dup",   tx_n - t0,      32'h4);
      check("bp_unstable", unstable,       32'h0);
      check("bp_addr",     32'(cap_addr),  32'h0124);
      check("bp_en_cnt",   en_cnt - e0,    32'h1);
      check("bp_b0", 32'(tx_log[8'(t0)]),     32'h0D);
      check("bp_b1", 32'(tx_log[8'(t0 + 1)]), 32'hF0);
      check("bp_b2", 32'(tx_log[8'(t0 + 2)]), 32'hFE);
      check("bp_b3", 32'(tx_log[8'(t0 + 3)]), 32'hCA);

      // 5: reset mid-frame, then a clean read
      e0 = en_cnt;
      send_byte(8'h57); send_byte(8'h10);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mid_rst_stall",    32'(cpu_stall), 32'h0);
      check("mid_rst_rx_ready", 32'(rx_ready),  32'h1);
      check("mid_rst_tx_valid", 32'(tx_valid),  32'h0);
      check("mid_rst_tx_data",  32'(tx_data),   32'h0);
      check("mid_rst_mem_addr", 32'(mem_addr),  32'h0);
      check("mid_rst_mem_din",  mem_din,        32'h0);
      check("mid_rst_mem_we",   32'(mem_we),    32'h0);
      check("mid_rst_en_cnt",   en_cnt - e0,    32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rd_word = 32'hA5A50001;
      t0 = tx_n;
      send_byte(8'h52); send_byte(8'h10); send_byte(8'h00);
      wait_tx("post_rst_tx_cnt", t0 + 4);
      check("post_rst_b0", 32'(tx_log[8'(t0)]),     32'h01);
      check("post_rst_b1", 32'(tx_log[8'(t0 + 1)]), 32'h00);
      check("post_rst_b2", 32'(tx_log[8'(t0 + 2)]), 32'hA5);
      check("post_rst_b3", 32'(tx_log[8'(t0 + 3)]), 32'hA5);

`ifdef UART_DBG_TIMEOUT_EN
      // 6: partial frame abandoned after 100 idle cycles
      e0 = en_cnt; t0 = tx_n;
      send_byte(8'h57); send_byte(8'h10);
      n = 0;
      while (cpu_stall && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("to_cycles",   32'(n),        32'd100);
      check("to_rx_ready", 32'(rx_ready), 32'h1);
      repeat (3) @(posedge clk);
      #2;
      check("to_en_cnt", en_cnt - e0, 32'h0);
      check("to_tx_cnt", tx_n - t0,   32'h0);
      send_byte(8'h57); send_byte(8'h20); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      wait_tx("to_next_tx_cnt", t0 + 1);
      check("to_next_ack",  32'(tx_log[8'(t0)]), 32'h06);
      check("to_next_addr", 32'(cap_addr),       32'h0020);
      check("to_next_din",  cap_din,             32'h04030201);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
